// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: single-entry instruction line buffer bridging the core fetch port to a req/ack memory with timeout-to-NOP
module inst_fetch_buf #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_inst_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        fetch_err_o
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t      state;
  logic [29:0] req_tag;
  logic [29:0] buf_tag;
  logic [31:0] buf_data;
  logic        buf_valid;
  logic [7:0]  cnt;
  logic        hit;
  logic        miss;
  logic        expire;
  logic        unused_byte_sel;
  assign unused_byte_sel = ^cpu_addr_i[1:0];
  assign hit        = cpu_ce_i && buf_valid && cpu_addr_i[31:2] == buf_tag;
  assign miss       = cpu_ce_i && !hit;
  assign expire     = state == REQ && !mem_ack_i && cnt == 8'(TIMEOUT - 1);
  assign cpu_inst_o = (!rst && hit) ? buf_data : '0;
  assign stallreq_o = !rst && miss;
  // Request side comes only from state and the latched tag, never from cpu_addr_i.
  assign mem_req_o  = !rst && state == REQ;
  assign mem_addr_o = mem_req_o ? {req_tag, 2'b00} : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_tag     <= '0;
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_data    <= '0;
      cnt         <= '0;
      fetch_err_o <= 1'b0;
    end else begin
      fetch_err_o <= expire;
      if (state == IDLE) begin
        if (miss) begin
          req_tag <= cpu_addr_i[31:2];
          cnt     <= '0;
          state   <= REQ;
        end
      end else if (mem_ack_i || expire) begin
        buf_valid <= 1'b1;
        buf_tag   <= req_tag;
        buf_data  <= mem_ack_i ? mem_rdata_i : NOP_WORD;
        state     <= IDLE;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb_inst_fetch_buf: directed latency scenarios plus randomized traffic against a transaction-level reference model
module tb_inst_fetch_buf;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        rst, cpu_ce_i, mem_ack_i;
  logic [31:0] cpu_addr_i, mem_rdata_i;
  logic [31:0] cpu_inst_o, mem_addr_o;
  logic        stallreq_o, mem_req_o, fetch_err_o;
  int checks = 0;
  int failures = 0;
  bit          m_busy, m_bv, m_err;
  logic [31:0] m_addr, m_data;
  logic [29:0] m_tag;
  int          n = 0;
  int          m_start;
  logic [31:0] o_inst, o_maddr;
  logic        o_stall, o_req, o_err;
  int          st, rq, er;
  inst_fetch_buf #(.TIMEOUT(TO), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i),
    .cpu_inst_o(cpu_inst_o), .stallreq_o(stallreq_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .fetch_err_o(fetch_err_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, n);
    end
  endtask
  // One cycle: drive, compare against the model's view, then advance the model by the same edge.
  task automatic cyc(input logic r, input logic ce, input logic [31:0] a, input logic ack, input logic [31:0] d);
    logic h;
    rst = r; cpu_ce_i = ce; cpu_addr_i = a; mem_ack_i = ack; mem_rdata_i = d;
    #2;
    o_inst = cpu_inst_o; o_stall = stallreq_o; o_req = mem_req_o; o_maddr = mem_addr_o; o_err = fetch_err_o;
    h = ce && m_bv && a[31:2] == m_tag;
    check("inst", o_inst, (!r && h) ? m_data : 32'h0);
    check("stall", o_stall, !r && ce && !h);
    check("req", o_req, !r && m_busy);
    check("maddr", o_maddr, (!r && m_busy) ? m_addr : 32'h0);
    check("err", o_err, m_err);
    if (r) begin
      m_busy = 0; m_bv = 0; m_tag = '0; m_data = '0; m_err = 0;
    end else begin
      m_err = 0;
      if (m_busy) begin
        if (ack || n - m_start == TO) begin
          m_bv = 1; m_tag = m_addr[31:2]; m_data = ack ? d : 32'h0; m_err = !ack; m_busy = 0;
        end
      end else if (ce && !h) begin
        m_busy = 1; m_addr = {a[31:2], 2'b00}; m_start = n;
      end
    end
    n++;
    @(posedge clk);
    #2;
  endtask
  // Miss-to-fill sequence; k<0 means the memory never answers.
  task automatic run_fetch(input logic [31:0] a, input int k, input logic [31:0] d, output int s, output int q, output int e);
    int len;
    len = (k < 0) ? TO + 1 : k + 2;
    s = 0; q = 0; e = 0;
    for (int i = 0; i < len; i++) begin
      cyc(1'b0, 1'b1, a, k >= 0 && i == k + 1, d);
      s += int'(o_stall); q += int'(o_req); e += int'(o_err);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic r, ce, ack;
    logic [31:0] a, d;
    rst = 1; cpu_ce_i = 0; cpu_addr_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    @(posedge clk);
    #2;
    cyc(1'b1, 1'b1, 32'h44, 1'b0, 32'h0);
    check("rst_stall", o_stall, 0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    run_fetch(32'h0, 0, 32'h3401_1100, st, rq, er);
    check("t1_stalls", st, 2);
    check("t1_reqs", rq, 1);
    check("t1_maddr", o_maddr, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
      check("t1_hit_inst", o_inst, 32'h3401_1100);
      check("t1_hit_req", o_req, 0);
    end
    run_fetch(32'h4, 3, 32'hA1B2_C3D4, st, rq, er);
    check("t3_stalls", st, 5);
    check("t3_reqs", rq, 4);
    cyc(1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
    check("t3_hit", o_inst, 32'hA1B2_C3D4);
    cyc(1'b0, 1'b1, 32'h6, 1'b0, 32'h0);
    check("t3_byte_hit", o_inst, 32'hA1B2_C3D4);
    check("t3_byte_stall", o_stall, 0);
    run_fetch(32'h40, -1, 32'h0, st, rq, er);
    check("to_stalls", st, TO + 1);
    check("to_reqs", rq, TO);
    check("to_err_early", er, 0);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    check("to_err", o_err, 1);
    check("to_nop", o_inst, 32'h0);
    check("to_nostall", o_stall, 0);
    cyc(1'b0, 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
    check("to_err_once", o_err, 0);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    check("idle_ack_ignored", o_inst, 32'h0);
    cyc(1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    check("sw_maddr_old", o_maddr, 32'h10);
    cyc(1'b0, 1'b1, 32'h20, 1'b1, 32'h1010_1010);
    check("sw_inst0", o_inst, 32'h0);
    cyc(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    check("sw_remiss", o_stall, 1);
    check("sw_inst1", o_inst, 32'h0);
    cyc(1'b0, 1'b1, 32'h20, 1'b1, 32'h2020_2020);
    check("sw_maddr_new", o_maddr, 32'h20);
    cyc(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    check("sw_data", o_inst, 32'h2020_2020);
    cyc(1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h80, 1'b1, 32'hBAD0_BAD0);
    check("rr_req_low", o_req, 0);
    run_fetch(32'h80, 1, 32'h600D_F00D, st, rq, er);
    check("rr_stalls", st, 3);
    cyc(1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    check("rr_data", o_inst, 32'h600D_F00D);
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom % 128) == 0;
      ce  = ($urandom % 4) != 0;
      a   = (32'($urandom_range(0, 5)) << 2) | 32'($urandom % 4);
      ack = m_busy ? (($urandom % 6) == 0) : (($urandom % 16) == 0);
      d   = $urandom;
      cyc(r, ce, a, ack, d);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
